// File: rtl/motor_ramp_ctrl_pkg.sv
// motor_ramp_pkg: shared types and helpers for the motor ramp controller.
//   motor_state_e  - controller state encoding (3 bits)
//   DUTY_W_DEF     - default duty / PWM counter width
//   sat_add        - saturating add, clamps at an upper limit
//   sat_sub        - saturating subtract, clamps at zero
// The helpers work on SAT_W bits. SAT_W is wider than DUTY_W+1 for any
// practical duty width, so sums and differences never wrap.
package motor_ramp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMED     = 3'd1,
    ST_CONFIRM   = 3'd2,
    ST_RAMP_UP   = 3'd3,
    ST_RUN       = 3'd4,
    ST_RAMP_DOWN = 3'd5,
    ST_LOCKOUT   = 3'd6
  } motor_state_e;

  localparam int DUTY_W_DEF = 8;
  localparam int SAT_W      = 32;

  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] step,
                                               input logic [SAT_W-1:0] limit);
    logic [SAT_W-1:0] sum;
    sum = a + step;
    if (sum > limit) begin
      return limit;
    end else begin
      return sum;
    end
  endfunction

  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] step);
    if (a > step) begin
      return a - step;
    end else begin
      return {SAT_W{1'b0}};
    end
  endfunction

endpackage

// File: rtl/motor_ramp_ctrl_pwm_gen.sv
// pwm_gen: free-running PWM counter and duty comparator.
// Ports:
//   clk    in   system clock
//   resetn in   synchronous active-low reset
//   duty   in   DUTY_W  duty value (registered upstream)
//   pwm    out  registered drive, high while counter < duty
// The period is 2^DUTY_W cycles; duty=0 keeps pwm constantly low.
module pwm_gen
  import motor_ramp_pkg::*;
#(
  parameter int DUTY_W = DUTY_W_DEF
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm
);

  logic [DUTY_W-1:0] pwm_cnt_r;
  logic              pwm_r;

  // Free-running counter (natural wrap) and registered duty compare.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pwm_cnt_r <= '0;
      pwm_r     <= 1'b0;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + DUTY_W'(1);
      pwm_r     <= (pwm_cnt_r < duty);
    end
  end

  assign pwm = pwm_r;

endmodule

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: turns the motor supervisor grant into a soft-started PWM
// drive. A start pulse arms the controller, the grant must then hold for
// CONFIRM_CYC cycles before the duty ramps up to DUTY_MAX. Losing the grant
// at any point after arming ends in LOCKOUT, which only reset clears.
// Ports:
//   clk     in   system clock
//   resetn  in   synchronous active-low reset
//   f       in   start pulse from supervisor FSM
//   g       in   motor-enable grant from supervisor FSM
//   pwm     out  motor drive (registered)
//   duty    out  DUTY_W current duty (registered)
//   running out  high while in RUN
//   lockout out  high while in LOCKOUT
// Build option MOTOR_RAMP_SOFTSTOP_EN: when defined, grant loss in RAMP_UP
// or RUN ramps the duty down before locking out. Otherwise the drive drops
// to zero duty and locks out at once.
module motor_ramp_ctrl
  import motor_ramp_pkg::*;
#(
  parameter int DUTY_W      = DUTY_W_DEF,
  parameter int DUTY_MAX    = 255,
  parameter int RAMP_STEP   = 4,
  parameter int RAMP_DIV    = 16,
  parameter int CONFIRM_CYC = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              f,
  input  logic              g,
  output logic              pwm,
  output logic [DUTY_W-1:0] duty,
  output logic              running,
  output logic              lockout
);

  localparam int PRESC_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam int CONF_W  = (CONFIRM_CYC > 1) ? $clog2(CONFIRM_CYC + 1) : 1;

  motor_state_e       state_r;
  logic [DUTY_W-1:0]  duty_r;
  logic [PRESC_W-1:0] presc_r;
  logic [CONF_W-1:0]  conf_cnt_r;
  logic               running_r;
  logic               lockout_r;

  logic               tick_s;
  logic               last_conf_s;
  logic [SAT_W-1:0]   duty_up_s;

  assign tick_s      = (presc_r == PRESC_W'(RAMP_DIV - 1));
  assign last_conf_s = (conf_cnt_r == CONF_W'(CONFIRM_CYC - 1));
  assign duty_up_s   = sat_add(SAT_W'(duty_r), SAT_W'(RAMP_STEP), SAT_W'(DUTY_MAX));

`ifdef MOTOR_RAMP_SOFTSTOP_EN
  logic [SAT_W-1:0]   duty_dn_s;
  assign duty_dn_s = sat_sub(SAT_W'(duty_r), SAT_W'(RAMP_STEP));
`endif

  // Controller FSM with ramp prescaler, confirm counter and status decodes.
  // running/lockout are written alongside the transition into their state so
  // they are valid in the same cycle the state is entered.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r    <= ST_IDLE;
      duty_r     <= '0;
      presc_r    <= '0;
      conf_cnt_r <= '0;
      running_r  <= 1'b0;
      lockout_r  <= 1'b0;
    end else begin
      running_r <= 1'b0;
      lockout_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (f) begin
            state_r <= ST_ARMED;
          end else begin
            state_r <= ST_IDLE;
          end
        end

        ST_ARMED: begin
          if (g) begin
            // The cycle that leaves ARMED already counts as the first
            // confirm cycle.
            conf_cnt_r <= CONF_W'(1);
            if (CONFIRM_CYC == 32'sd1) begin
              state_r <= ST_RAMP_UP;
              presc_r <= '0;
            end else begin
              state_r <= ST_CONFIRM;
            end
          end else begin
            state_r <= ST_ARMED;
          end
        end

        ST_CONFIRM: begin
          if (!g) begin
            state_r   <= ST_LOCKOUT;
            duty_r    <= '0;
            lockout_r <= 1'b1;
          end else if (last_conf_s) begin
            state_r <= ST_RAMP_UP;
            presc_r <= '0;
          end else begin
            conf_cnt_r <= conf_cnt_r + CONF_W'(1);
          end
        end

        ST_RAMP_UP: begin
          // Grant loss wins over a coincident ramp tick.
          if (!g) begin
`ifdef MOTOR_RAMP_SOFTSTOP_EN
            state_r <= ST_RAMP_DOWN;
            presc_r <= '0;
`else
            state_r   <= ST_LOCKOUT;
            duty_r    <= '0;
            lockout_r <= 1'b1;
`endif
          end else if (tick_s) begin
            duty_r  <= duty_up_s[DUTY_W-1:0];
            presc_r <= '0;
            if (duty_up_s == SAT_W'(DUTY_MAX)) begin
              state_r   <= ST_RUN;
              running_r <= 1'b1;
            end else begin
              state_r <= ST_RAMP_UP;
            end
          end else begin
            presc_r <= presc_r + PRESC_W'(1);
          end
        end

        ST_RUN: begin
          if (!g) begin
`ifdef MOTOR_RAMP_SOFTSTOP_EN
            state_r <= ST_RAMP_DOWN;
            presc_r <= '0;
            duty_r  <= DUTY_W'(DUTY_MAX);
`else
            state_r   <= ST_LOCKOUT;
            duty_r    <= '0;
            lockout_r <= 1'b1;
`endif
          end else begin
            state_r   <= ST_RUN;
            duty_r    <= DUTY_W'(DUTY_MAX);
            running_r <= 1'b1;
          end
        end

`ifdef MOTOR_RAMP_SOFTSTOP_EN
        ST_RAMP_DOWN: begin
          // The grant is deliberately ignored here: once stopping, always stop.
          if (duty_r == '0) begin
            state_r   <= ST_LOCKOUT;
            lockout_r <= 1'b1;
          end else if (tick_s) begin
            duty_r  <= duty_dn_s[DUTY_W-1:0];
            presc_r <= '0;
            if (duty_dn_s == '0) begin
              state_r   <= ST_LOCKOUT;
              lockout_r <= 1'b1;
            end else begin
              state_r <= ST_RAMP_DOWN;
            end
          end else begin
            presc_r <= presc_r + PRESC_W'(1);
          end
        end
`endif

        ST_LOCKOUT: begin
          state_r   <= ST_LOCKOUT;
          duty_r    <= '0;
          lockout_r <= 1'b1;
        end

        // Unreachable encodings fall into the safe absorbing state.
        default: begin
          state_r   <= ST_LOCKOUT;
          duty_r    <= '0;
          lockout_r <= 1'b1;
        end
      endcase
    end
  end

  pwm_gen #(
    .DUTY_W(DUTY_W)
  ) u_pwm_gen (
    .clk   (clk),
    .resetn(resetn),
    .duty  (duty_r),
    .pwm   (pwm)
  );

  assign duty    = duty_r;
  assign running = running_r;
  assign lockout = lockout_r;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Directed testbench for motor_ramp_ctrl (RAMP_DIV=2, RAMP_STEP=64,
// CONFIRM_CYC=3). A second instance with DUTY_MAX=64 checks PWM duty cycle.
// Expectations follow the MOTOR_RAMP_SOFTSTOP_EN setting of the build.
module tb_motor_ramp_ctrl;

  logic       clk = 1'b0;
  logic       resetn, f, g;
  logic       pwm, running, lockout;
  logic [7:0] duty;

  logic       resetn64, f64, g64;
  logic       pwm64, running64, lockout64;
  logic [7:0] duty64;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  motor_ramp_ctrl #(
    .DUTY_W(8), .DUTY_MAX(255), .RAMP_STEP(64), .RAMP_DIV(2), .CONFIRM_CYC(3)
  ) dut (
    .clk(clk), .resetn(resetn), .f(f), .g(g),
    .pwm(pwm), .duty(duty), .running(running), .lockout(lockout)
  );

  motor_ramp_ctrl #(
    .DUTY_W(8), .DUTY_MAX(64), .RAMP_STEP(64), .RAMP_DIV(2), .CONFIRM_CYC(3)
  ) dut64 (
    .clk(clk), .resetn(resetn64), .f(f64), .g(g64),
    .pwm(pwm64), .duty(duty64), .running(running64), .lockout(lockout64)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n clocks; outputs are sampled 1 time unit after the edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Expected duty k edges after g rises: RAMP_UP entered at k=3,
  // first tick at k=5, then every 2 edges; 192+64 saturates to 255.
  function automatic int exp_up(input int k);
    if (k <= 4) return 0;
    else if (k <= 6) return 64;
    else if (k <= 8) return 128;
    else if (k <= 10) return 192;
    else return 255;
  endfunction

  // Expected duty k edges after g drops in RUN with soft stop.
  function automatic int exp_down(input int k);
    if (k <= 2) return 255;
    else if (k <= 4) return 191;
    else if (k <= 6) return 127;
    else if (k <= 8) return 63;
    else return 0;
  endfunction

  // f pulse then g held; checks n edges of the ramp.
  task automatic start_ramp(input int n, input string tag);
    f = 1'b1;
    step(1);
    f = 1'b0;
    g = 1'b1;
    for (int k = 1; k <= n; k++) begin
      step(1);
      check({tag, " duty"}, int'(duty), exp_up(k));
      check({tag, " running"}, int'(running), (k >= 11) ? 1 : 0);
    end
  endtask

  initial begin
    int cnt;
    resetn = 1'b0; f = 1'b0; g = 1'b0;
    resetn64 = 1'b0; f64 = 1'b0; g64 = 1'b0;
    step(2);
    check("rst duty", int'(duty), 0);
    check("rst pwm", int'(pwm), 0);
    check("rst running", int'(running), 0);
    check("rst lockout", int'(lockout), 0);

    // g without f must be ignored in IDLE
    resetn = 1'b1;
    g = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      check("idle duty", int'(duty), 0);
      check("idle running", int'(running), 0);
      check("idle pwm", int'(pwm), 0);
    end
    g = 1'b0;
    step(1);

    // Normal start to RUN
    start_ramp(12, "ramp");
    check("ramp lockout", int'(lockout), 0);

    // Full-speed PWM: 255 of 256 cycles high
    step(1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      cnt += int'(pwm);
    end
    check("pwm255 count", cnt, 255);

    // Grant loss in RUN
    g = 1'b0;
`ifdef MOTOR_RAMP_SOFTSTOP_EN
    for (int k = 1; k <= 9; k++) begin
      step(1);
      check("softstop duty", int'(duty), exp_down(k));
      check("softstop lockout", int'(lockout), (k == 9) ? 1 : 0);
      check("softstop running", int'(running), 0);
    end
`else
    step(1);
    check("hardstop duty", int'(duty), 0);
    check("hardstop lockout", int'(lockout), 1);
    check("hardstop running", int'(running), 0);
`endif
    step(1);
    check("stop pwm", int'(pwm), 0);

    // LOCKOUT is absorbing
    g = 1'b1; f = 1'b1;
    step(1);
    f = 1'b0;
    step(5);
    check("lock hold lockout", int'(lockout), 1);
    check("lock hold duty", int'(duty), 0);
    check("lock hold running", int'(running), 0);

    // Confirm abort: g high for 2 cycles only
    resetn = 1'b0; g = 1'b0;
    step(1);
    resetn = 1'b1;
    check("abort rst lockout", int'(lockout), 0);
    f = 1'b1;
    step(1);
    f = 1'b0;
    g = 1'b1;
    step(2);
    check("abort pre lockout", int'(lockout), 0);
    g = 1'b0;
    step(1);
    check("abort lockout", int'(lockout), 1);
    check("abort duty", int'(duty), 0);
    g = 1'b1; f = 1'b1;
    step(1);
    f = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1);
      check("abort hold duty", int'(duty), 0);
      check("abort hold lockout", int'(lockout), 1);
      check("abort hold running", int'(running), 0);
    end

    // Reset mid-ramp at duty=128, then restart
    resetn = 1'b0; g = 1'b0;
    step(1);
    resetn = 1'b1;
    step(1);
    start_ramp(7, "midramp");
    resetn = 1'b0;
    step(1);
    check("midrst duty", int'(duty), 0);
    check("midrst pwm", int'(pwm), 0);
    check("midrst running", int'(running), 0);
    check("midrst lockout", int'(lockout), 0);
    resetn = 1'b1;
    step(4);
    check("midrst idle duty", int'(duty), 0);
    g = 1'b0;
    step(1);
    start_ramp(11, "restart");

    // DUTY_MAX=64 build: single tick reaches RUN, pwm high 64/256
    resetn64 = 1'b1;
    step(1);
    f64 = 1'b1;
    step(1);
    f64 = 1'b0;
    g64 = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (running64 == 1'b1) break;
      step(1);
    end
    check("dut64 running", int'(running64), 1);
    check("dut64 duty", int'(duty64), 64);
    step(1);
    cnt = 0;
    for (int i = 0; i < 256; i++) begin
      step(1);
      cnt += int'(pwm64);
    end
    check("pwm64 count", cnt, 64);
    check("dut64 lockout", int'(lockout64), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
